// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB3 register bank with fixed wait states and pslverr; define APB_SLV_PSTRB_EN for APB4 byte strobes
module apb_reg_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_CYCLES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK = 'h01,
  parameter logic [DATA_WIDTH-1:0] RST_VAL = '0
) (
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [3:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0] prdata,
  output logic pready,
  output logic pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0] wr_pulse
);
  localparam int IW = ADDR_WIDTH - 2;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IW-1:0] a_idx, sel_idx;
  logic [DATA_WIDTH-1:0] a_wdata, rdata, wmask;
  logic [3:0] a_strb, strb;
  logic a_write, a_err, err_now, err_cur, ro_hit, setup, commit;
  logic unused_ok;
`ifdef APB_SLV_PSTRB_EN
  assign strb = pstrb;
`else
  assign strb = 4'hf;
`endif
  assign unused_ok = ^status_in;
  assign setup = psel && !penable;
  assign sel_idx = state == IDLE ? paddr[ADDR_WIDTH-1:2] : a_idx;
  assign err_now = |paddr[1:0] || int'(paddr[ADDR_WIDTH-1:2]) >= NUM_REGS || (pwrite && (ro_hit || strb == 4'h0));
  assign err_cur = state == IDLE ? err_now : a_err;
  assign wmask = {{8{a_strb[3]}}, {8{a_strb[2]}}, {8{a_strb[1]}}, {8{a_strb[0]}}};
  assign commit = state == ACK && a_write && !a_err && psel && penable;
  // Write to a read-only register is detected from the live address during setup
  always_comb begin
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) ro_hit = ro_hit | (paddr[ADDR_WIDTH-1:2] == IW'(i) && RO_MASK[i]);
  end
  // Read mux: RO registers return hardware status, RW registers their stored value
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sel_idx == IW'(i)) rdata = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
  end
  // Next-state logic: setup -> optional wait states -> single ACK cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (setup) begin
        state_n = WAIT_CYCLES == 0 ? ACK : WAIT;
        cnt_n = WAIT_CYCLES == 0 ? 3'd0 : 3'd1;
      end
      WAIT: if (!psel) begin
        state_n = IDLE;
        cnt_n = '0;
      end else if (cnt == 3'(WAIT_CYCLES)) state_n = ACK;
      else cnt_n = cnt + 3'd1;
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  // State register
  always_ff @(posedge pclk) begin
    state <= preset ? IDLE : state_n;
    cnt <= preset ? '0 : cnt_n;
  end
  // Transfer capture and registered response; pready mirrors the ACK state
  always_ff @(posedge pclk) begin
    if (preset) begin
      a_idx <= '0;
      a_write <= 1'b0;
      a_wdata <= '0;
      a_strb <= '0;
      a_err <= 1'b0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
    end else begin
      if (state == IDLE && setup) begin
        a_idx <= paddr[ADDR_WIDTH-1:2];
        a_write <= pwrite;
        a_wdata <= pwdata;
        a_strb <= strb;
        a_err <= err_now;
      end
      pready <= state_n == ACK;
      pslverr <= state_n == ACK && err_cur;
      prdata <= state_n == ACK && !err_cur ? rdata : '0;
    end
  end
  // Register bank update and write strobe, committed as ACK completes
  always_ff @(posedge pclk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (preset) regs[i] <= RST_VAL;
      else if (commit && a_idx == IW'(i)) regs[i] <= (regs[i] & ~wmask) | (a_wdata & wmask);
      wr_pulse[i] <= !preset && commit && a_idx == IW'(i);
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
  end
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: scoreboard bench for apb_reg_slave (WAIT_CYCLES=1 and zero-wait instances)
module tb_apb_reg_slave;
  typedef struct {
    int d;
    int cyc;
    logic err;
    logic chk;
    logic [31:0] rd;
    logic [7:0] pulse;
  } exp_t;
`ifdef APB_SLV_PSTRB_EN
  localparam bit PSTRB = 1'b1;
`else
  localparam bit PSTRB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic psel [2], penable [2], pwrite [2], pready [2], pslverr [2];
  logic [11:0] paddr [2];
  logic [31:0] pwdata [2], prdata [2];
  logic [3:0] pstrb [2];
  logic [255:0] status_in;
  logic [255:0] reg_out [2];
  logic [7:0] wr_pulse [2];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  exp_t sb [$];
  logic pend = 1'b0;
  int pd;
  logic [7:0] pp;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  apb_reg_slave dut (
    .pclk(clk), .preset(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb[0]),
`endif
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .status_in(status_in), .reg_out(reg_out[0]), .wr_pulse(wr_pulse[0])
  );
  apb_reg_slave #(.WAIT_CYCLES(0)) dut_zw (
    .pclk(clk), .preset(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb[1]),
`endif
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .status_in(status_in), .reg_out(reg_out[1]), .wr_pulse(wr_pulse[1])
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic apb(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic err, input logic [31:0] rd, input logic [7:0] pulse);
    exp_t e;
    @(posedge clk); #1;
    psel[d] = 1'b1;
    penable[d] = 1'b0;
    pwrite[d] = wr;
    paddr[d] = a;
    pwdata[d] = wd;
    pstrb[d] = st;
    e.d = d;
    e.cyc = cyc + 1 + (d == 0 ? 1 : 0);
    e.err = err | (PSTRB && wr && st == 4'h0);
    e.chk = !wr || e.err;
    e.rd = e.err ? 32'h0 : rd;
    e.pulse = e.err ? 8'h0 : pulse;
    sb.push_back(e);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pready[d]) break;
      if (i == 15) begin
        tests++;
        fails++;
        $display("FAIL timeout dut%0d addr %h: pready never rose", d, a);
      end
    end
  endtask
  task automatic idle(input int d);
    @(posedge clk); #1;
    psel[d] = 1'b0;
    penable[d] = 1'b0;
  endtask
  // Monitor: pops an expectation at each pready and checks wr_pulse the cycle after
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk($sformatf("wr_pulse dut%0d", pd), 32'(wr_pulse[pd]), 32'(pp));
      pend = 1'b0;
    end
    for (int d = 0; d < 2; d++) if (pready[d]) begin
      if (sb.size() == 0) chk($sformatf("unexpected pready dut%0d", d), 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("scoreboard dut", d, e.d);
        chk($sformatf("latency dut%0d", d), cyc, e.cyc);
        chk($sformatf("pslverr dut%0d", d), 32'(pslverr[d]), 32'(e.err));
        if (e.chk) chk($sformatf("prdata dut%0d", d), prdata[d], e.rd);
        pend = 1'b1;
        pd = d;
        pp = e.pulse;
      end
    end
  end
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0;
      penable[d] = 1'b0;
      pwrite[d] = 1'b0;
      paddr[d] = '0;
      pwdata[d] = '0;
      pstrb[d] = 4'hf;
    end
    status_in = '0;
    status_in[31:0] = 32'hcafe0001;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset pready", 32'(pready[0]), 0);
    chk("reset prdata", prdata[0], 0);
    chk("reset wr_pulse", 32'(wr_pulse[0]), 0);
    chk("reset reg_out", reg_out[0][63:32], 0);
    // reset asserted mid-WAIT during a write discards it
    @(posedge clk); #1;
    psel[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 12'h4; pwdata[0] = 32'hdeadbeef;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    psel[0] = 1'b0;
    penable[0] = 1'b0;
    @(negedge clk);
    chk("midwait rst pready", 32'(pready[0]), 0);
    chk("midwait rst pslverr", 32'(pslverr[0]), 0);
    chk("midwait rst prdata", prdata[0], 0);
    @(negedge clk);
    chk("midwait rst wr_pulse", 32'(wr_pulse[0]), 0);
    apb(0, 0, 12'h4, 0, 4'hf, 0, 32'h0, 0);
    // basic write/read, one wait state
    apb(0, 1, 12'h8, 32'h12345678, 4'hf, 0, 0, 8'h04);
    apb(0, 0, 12'h8, 0, 4'hf, 0, 32'h12345678, 0);
    idle(0);
    chk("reg_out slice2", reg_out[0][95:64], 32'h12345678);
    chk("reg_out RO slice", reg_out[0][31:0], 0);
    // read-only register
    apb(0, 0, 12'h0, 0, 4'hf, 0, 32'hcafe0001, 0);
    apb(0, 1, 12'h0, 32'hffffffff, 4'hf, 1, 0, 0);
    apb(0, 0, 12'h0, 0, 4'hf, 0, 32'hcafe0001, 0);
    // address errors and last valid register
    apb(0, 0, 12'h20, 0, 4'hf, 1, 0, 0);
    apb(0, 1, 12'h6, 32'h1, 4'hf, 1, 0, 0);
    apb(0, 1, 12'h1c, 32'hfeedf00d, 4'hf, 0, 0, 8'h80);
    apb(0, 0, 12'h1c, 0, 4'hf, 0, 32'hfeedf00d, 0);
    idle(0);
    // psel dropped during WAIT aborts the write
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h10; pwdata[0] = 32'h77;
    @(posedge clk); #1;
    psel[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort pready", 32'(pready[0]), 0);
    end
    apb(0, 0, 12'h10, 0, 4'hf, 0, 32'h0, 0);
    idle(0);
    // penable without setup is ignored
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 12'h8;
    repeat (3) begin
      @(negedge clk);
      chk("no-setup pready", 32'(pready[0]), 0);
    end
    idle(0);
    // zero-wait instance with back-to-back transfers
    apb(1, 0, 12'h4, 0, 4'hf, 0, 32'h0, 0);
    apb(1, 1, 12'h4, 32'ha5a5a5a5, 4'hf, 0, 0, 8'h02);
    apb(1, 1, 12'h8, 32'h5a5a5a5a, 4'hf, 0, 0, 8'h04);
    apb(1, 0, 12'h4, 0, 4'hf, 0, 32'ha5a5a5a5, 0);
    apb(1, 0, 12'h8, 0, 4'hf, 0, 32'h5a5a5a5a, 0);
    idle(1);
`ifdef APB_SLV_PSTRB_EN
    apb(0, 1, 12'hc, 32'h11223344, 4'hf, 0, 0, 8'h08);
    apb(0, 1, 12'hc, 32'haabbccdd, 4'b0101, 0, 0, 8'h08);
    apb(0, 0, 12'hc, 0, 4'hf, 0, 32'h11bb33dd, 0);
    apb(0, 1, 12'hc, 32'h0, 4'b0000, 1, 0, 0);
    apb(0, 0, 12'hc, 0, 4'hf, 0, 32'h11bb33dd, 0);
    idle(0);
`endif
    repeat (4) @(posedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
APB3 completer hosting a bank of NUM_REGS 32-bit control/status registers. It sits behind one psel_int output of the bridge's address decoder, on the responder end of the APB link. It inserts a fixed, configurable number of wait states and flags erroneous accesses with pslverr. It exposes control registers to hardware and samples hardware status into read-only registers.

Parameters:
- ADDR_WIDTH, 12, width of paddr; only this window offset is decoded locally.
- DATA_WIDTH, 32, pwdata/prdata width; must be 32.
- NUM_REGS, 8, number of word registers at offsets 0x0, 0x4, ... up to 4*(NUM_REGS-1); range 1..16.
- WAIT_CYCLES, 1, pready-low cycles inserted in the access phase; range 0..7.
- RO_MASK, 8'h01, bit i=1 makes register i read-only; its read data comes from status_in.
- RST_VAL, 32'h0, reset value of every read/write register.

Ports:
- pclk  input  1  APB clock; all logic on the rising edge.
- preset  input  1  synchronous, active-high reset.
- psel  input  1  slave select, driven by the bridge's decoder output.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1=write, 0=read.
- paddr  input  ADDR_WIDTH  byte address within the slave window.
- pwdata  input  DATA_WIDTH  write data.
- prdata  output  DATA_WIDTH  read data; valid only while pready=1.
- pready  output  1  transfer completion, registered.
- pslverr  output  1  error response, qualified by pready.
- status_in  input  NUM_REGS*DATA_WIDTH  hardware status; slice i is returned for RO register i.
- reg_out  output  NUM_REGS*DATA_WIDTH  current RW register contents; RO slices are driven 0.
- wr_pulse  output  NUM_REGS  one-cycle pulse in the cycle after a successful write to register i.

Behaviour:
- Reset (preset=1 at a clock edge): state=IDLE, wait counter=0, pready=0, pslverr=0, prdata=0, wr_pulse=0, RW registers=RST_VAL. Reset takes priority over any transfer in flight; an interrupted write is discarded.
- FSM states are IDLE, WAIT and ACK.
- IDLE: a setup phase is psel=1 and penable=0.
  - On a setup phase, latch paddr, pwrite and pwdata and compute the error flag.
  - If WAIT_CYCLES=0, go to ACK and set pready=1 for the next cycle. Otherwise go to WAIT with counter=1.
- WAIT: pready=0.
  - If psel=0, abort to IDLE; no register update.
  - If counter==WAIT_CYCLES, go to ACK and set pready=1. Otherwise increment the counter.
- ACK: pready=1 for exactly one cycle, then IDLE with pready=0. pready is never high outside ACK.
- Timing: with setup in cycle T0, pready is high in cycle T1+WAIT_CYCLES.
- The error flag is set when any of the following holds:
  - paddr[1:0]!=0;
  - word index paddr[ADDR_WIDTH-1:2] >= NUM_REGS;
  - a write to a register whose RO_MASK bit is 1.
- Read data:
  - prdata is loaded on the edge that enters ACK: the RW register value, or the status_in slice for an RO register.
  - On error, prdata=0.
  - prdata returns to 0 when leaving ACK.
- pslverr is loaded alongside pready and equals the error flag; it is 0 whenever pready=0.
- Writes commit on the edge that ends ACK, only when the error flag=0 and psel and penable are still high. wr_pulse[i] is high in the following cycle.
- Back-to-back transfers: a new setup phase in the cycle after ACK is accepted. There is no required idle gap beyond APB's own setup phase.
- Protocol violation: penable=1 seen in IDLE without a preceding setup phase is ignored, with no response.

Optional Feature:
- Macro: APB_SLV_PSTRB_EN.
- When defined:
  - an extra input pstrb (4 bits, APB4) is present and latched in setup;
  - a write updates only the byte lanes with pstrb[k]=1;
  - pstrb=4'b0000 on a write is an error (pslverr=1, no update).
- When undefined: no pstrb port, and writes update all 32 bits.

Test Plan:
- Reset check: assert preset mid-WAIT during a write of 0xDEADBEEF to offset 0x4 → pready=0, pslverr=0, prdata=0, and register 1 reads 0x0 afterwards.
- Write/read with WAIT_CYCLES=1: write 0x12345678 to 0x8 → pready high in T2 with pslverr=0, and wr_pulse[2] high in T3. A read of 0x8 then returns 0x12345678 with pready in T2.
- Zero-wait build (WAIT_CYCLES=0): read at 0x4 → pready=1 in T1, and back-to-back writes to 0x4 then 0x8 both complete, each in 2 cycles.
- Read-only register: with status_in slice0=0xCAFE0001, a read of 0x0 returns 0xCAFE0001. A write of 0xFFFFFFFF to 0x0 → pslverr=1, and the value read back is still 0xCAFE0001.
- Errors:
  - address 0x20 with NUM_REGS=8 → pslverr=1 and prdata=0;
  - address 0x6 (misaligned) → pslverr=1;
  - in both cases wr_pulse stays 0.
- Byte strobes (APB_SLV_PSTRB_EN defined): register 3=0x11223344; write 0xAABBCCDD to 0xC with pstrb=4'b0101 → reads back 0x11BB33DD. pstrb=0 → pslverr=1.
